data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Shares the single data memory port (256 x 9, combinational read, write on clock edge) between two requesters: requester 0 is the core load/store path, requester 1 is the loader/debug path.
- Arbitrates round-robin and registers the winning command onto the memory port.
- Returns read data with fixed latency.
- Includes a clear engine that sweeps every address with CLEAR_VAL, so clearing is not done by a memory-wide reset loop.

Parameters:
ADDR_W, 8, memory address width; DEPTH = 2**ADDR_W
DATA_W, 9, memory word width
CLEAR_VAL, 0, value written to each word during a clear sweep

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
r0_req  in  1  requester 0 access request, held until r0_gnt
r0_we  in  1  requester 0 write (1) / read (0)
r0_addr  in  ADDR_W  requester 0 address
r0_wdata  in  DATA_W  requester 0 write data
r0_gnt  out  1  one-cycle pulse: command is on the memory port this cycle
r0_rvalid  out  1  one-cycle pulse: r0_rdata valid
r0_rdata  out  DATA_W  read data, held until the next r0 read completes
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0_* for requester 1
clr_start  in  1  pulse: begin clear sweep
clr_busy  out  1  high while a sweep is in progress
mem_we  out  1  to memory write enable
mem_a  out  ADDR_W  to memory address
mem_d  out  DATA_W  to memory write data
mem_spo  in  DATA_W  from memory combinational read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - All gnt, rvalid, rdata, mem_we, mem_a, mem_d and clr_busy are 0.
  - Round-robin pointer favours r0.
  - Reset mid-sweep or mid-access aborts it; nothing is retried.
- FSM states:
  - IDLE: memory port inactive, mem_we = 0.
  - ACCESS: a registered requester command is on mem_*.
  - CLEAR: sweep in progress.
- Arbitration at each edge in IDLE or ACCESS:
  - Eligible set = req masked by the current-cycle gnt, so a granted requester is not re-granted on its own still-high req.
  - clr_start has priority over all requests and moves the FSM to CLEAR.
  - Otherwise, if any eligible req: winner = pointer side if eligible, else the other side. Load mem_a, mem_we and mem_d from the winner, go to (or stay in) ACCESS, and set the pointer to the loser.
  - Otherwise go to IDLE.
- Timing:
  - Request sampled at edge N → rX_gnt high during cycle N+1, with the command on mem_*.
  - Requester deasserts req or presents the next command after sampling gnt.
  - Back-to-back grants are allowed: at most one access per cycle.
- Writes:
  - mem_we = 1 for exactly the granted cycle.
  - Memory updates at the end of cycle N+1.
- Reads:
  - mem_spo is captured into rX_rdata at the end of cycle N+1.
  - rX_rvalid pulses in cycle N+2, giving read latency 2 from the request edge.
  - A read following a write to the same address returns the new data.
- Fairness: with both requests continuously high, grants alternate r0, r1, r0, … with no starvation.
- CLEAR:
  - clr_busy high from the first sweep cycle until the cycle after the last write.
  - mem_a steps 0..DEPTH-1, one per cycle, with mem_we = 1 and mem_d = CLEAR_VAL, so the sweep lasts DEPTH cycles.
  - Requests pending during CLEAR are not granted; they are arbitrated normally once the FSM returns to IDLE.
  - clr_start while clr_busy is ignored.
  - The address counter wraps DEPTH-1 → 0 on exit.
- Simultaneous events:
  - clr_start with both reqs: clear wins.
  - If an rvalid is due in the cycle CLEAR is entered, the rvalid still issues.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, FSM state encoding (IDLE, ACCESS, CLEAR), requester index constants.
- One natural sub-module, rr_arbiter2: 2-way round-robin pick with pointer and mask input, about 30 lines.
- FSM, command registers and clear counter stay in the top level.

Test Plan:
- Reset, then r0 write addr 0x10 data 0x1A5, then r0 read 0x10:
  - r0_gnt one cycle after each request.
  - r0_rvalid two cycles after the read request, with r0_rdata = 0x1A5.
- r0 and r1 both request continuously, r0 writing addr 0x01 and r1 writing addr 0x02, for 6 grants:
  - Grant order r0, r1, r0, r1, r0, r1.
  - No cycle with both gnt high.
  - mem_we asserted 6 consecutive cycles.
- Fill addr 0x00, 0x7F, 0xFF with 0x155, pulse clr_start:
  - clr_busy high for 256 cycles.
  - mem_a 0..255.
  - Subsequent reads of all three addresses return 0.
- clr_start asserted together with r1_req:
  - Sweep runs first; r1_gnt occurs only after clr_busy falls.
  - A second clr_start mid-sweep has no effect, so the sweep still lasts 256 cycles.
- rst_n pulsed low at sweep address 0x40:
  - Outputs immediately 0 and FSM IDLE.
  - Addresses ≥ 0x40 keep their pre-clear contents.
- r1 write then r0 read of the same address in consecutive grant cycles: r0_rdata equals r1's write data.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and defaults for the data memory arbiter: FSM encoding,
// requester indices and default port widths.
package data_memory_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 9;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: the pointer side wins when eligible, otherwise
// the other side. Masked requesters are never eligible.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       ptr,
  output logic       any,
  output logic       win
);

  logic [1:0] elig;

  always_comb begin
    elig = req & ~mask;
    any  = |elig;
    win  = ptr;
    if (!elig[ptr]) win = ~ptr;
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one combinational-read data memory port between the core (r0) and
// the loader/debug path (r1), with a clear engine that sweeps every address.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_spo
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state, state_nxt;
  logic [1:0]        gnt_p0, gnt_nxt;
  logic              we_p0, we_nxt;
  logic [ADDR_W-1:0] addr_p0, addr_nxt;
  logic [DATA_W-1:0] data_p0, data_nxt;
  logic              busy, busy_nxt;
  logic              ptr, ptr_nxt;
  logic              arb_any, arb_win;

  logic [1:0]        rd_vld_p1;
  logic [DATA_W-1:0] rd_data0_p1, rd_data1_p1;

  // The current grant masks its own still-high request for one edge.
  rr_arbiter2 u_arb (
    .req  ({r1_req, r0_req}),
    .mask (gnt_p0),
    .ptr  (ptr),
    .any  (arb_any),
    .win  (arb_win)
  );

  always_comb begin
    state_nxt = state;
    gnt_nxt   = '0;
    we_nxt    = 1'b0;
    addr_nxt  = addr_p0;
    data_nxt  = data_p0;
    busy_nxt  = 1'b0;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE, ST_ACCESS: begin
        if (clr_start) begin
          state_nxt = ST_CLEAR;
          we_nxt    = 1'b1;
          addr_nxt  = '0;
          data_nxt  = CLEAR_VAL;
          busy_nxt  = 1'b1;
        end else if (arb_any) begin
          state_nxt        = ST_ACCESS;
          gnt_nxt[arb_win] = 1'b1;
          ptr_nxt          = ~arb_win;
          if (arb_win == REQ1[0]) begin
            we_nxt   = r1_we;
            addr_nxt = r1_addr;
            data_nxt = r1_wdata;
          end else begin
            we_nxt   = r0_we;
            addr_nxt = r0_addr;
            data_nxt = r0_wdata;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Incrementing past the last address wraps the counter back to 0.
        addr_nxt = addr_p0 + 1'b1;
        if (addr_p0 == ADDR_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          we_nxt   = 1'b1;
          data_nxt = CLEAR_VAL;
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p0: registered command on the memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_p0  <= '0;
      we_p0   <= 1'b0;
      addr_p0 <= '0;
      data_p0 <= '0;
      busy    <= 1'b0;
      ptr     <= 1'b0;
    end else begin
      gnt_p0  <= gnt_nxt;
      we_p0   <= we_nxt;
      addr_p0 <= addr_nxt;
      data_p0 <= data_nxt;
      busy    <= busy_nxt;
      ptr     <= ptr_nxt;
    end
  end

  // Stage p1: read data captured at the end of the grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1   <= '0;
      rd_data0_p1 <= '0;
      rd_data1_p1 <= '0;
    end else begin
      rd_vld_p1 <= gnt_p0 & {2{~we_p0}};
      if (gnt_p0[REQ0] && !we_p0) rd_data0_p1 <= mem_spo;
      if (gnt_p0[REQ1] && !we_p0) rd_data1_p1 <= mem_spo;
    end
  end

  assign r0_gnt    = gnt_p0[REQ0];
  assign r1_gnt    = gnt_p0[REQ1];
  assign r0_rvalid = rd_vld_p1[REQ0];
  assign r1_rvalid = rd_vld_p1[REQ1];
  assign r0_rdata  = rd_data0_p1;
  assign r1_rdata  = rd_data1_p1;
  assign clr_busy  = busy;
  assign mem_we    = we_p0;
  assign mem_a     = addr_p0;
  assign mem_d     = data_p0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: a behavioural 256x9 memory on the
// port, a shadow copy for expected read data, and per-requester read queues.
`timescale 1ns/1ps
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              r0_req, r0_we, r1_req, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;
  logic              r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic              clr_start, clr_busy, mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d, mem_spo;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int sweep_idx = 0, sweep_err = 0, busy_run = 0, busy_len = 0;

  data_memory_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_spo(mem_spo)
  );

  always #5 clk = ~clk;

  assign mem_spo = mem[mem_a];
  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wipe(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ref_mem[i] = '0;
  endtask

  // Issue one command, wait for its grant and check the port contents then.
  task automatic access(input int id, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, output int lat);
    int  n;
    logic seen;
    n = 0;
    seen = 1'b0;
    if (id == 0) begin
      r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = data;
    end else begin
      r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = data;
    end
    if (we) ref_mem[addr] = data;
    else if (id == 0) q0.push_back(ref_mem[addr]);
    else q1.push_back(ref_mem[addr]);
    while (!seen && n < 2000) begin
      step();
      n++;
      seen = (id == 0) ? r0_gnt : r1_gnt;
    end
    lat = n;
    check("gnt_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("gnt_mem_we", 32'(mem_we), 32'(we));
      check("gnt_mem_a", 32'(mem_a), 32'(addr));
      if (we) check("gnt_mem_d", 32'(mem_d), 32'(data));
    end
    if (id == 0) r0_req = 1'b0;
    else r1_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && r0_rvalid) begin
      check("r0_rvalid_pending", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) check("r0_rdata", 32'(r0_rdata), 32'(q0.pop_front()));
    end
    if (rst_n && r1_rvalid) begin
      check("r1_rvalid_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) check("r1_rdata", 32'(r1_rdata), 32'(q1.pop_front()));
    end
    if (clr_busy) begin
      if (!(mem_we && mem_a == sweep_idx[ADDR_W-1:0] && mem_d == '0)) sweep_err++;
      sweep_idx++;
      busy_run++;
    end else if (busy_run != 0) begin
      busy_len  = busy_run;
      busy_run  = 0;
      sweep_idx = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, la, lb, n, ngr, werun, cyc;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    clr_start = 0;
    wipe(0, DEPTH-1);

    // Reset state
    rst_n = 1'b0;
    repeat (2) step();
    check("rst_gnt", 32'({r0_gnt, r1_gnt}), 32'd0);
    check("rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
    check("rst_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
    check("rst_mem", 32'({mem_we, mem_a, mem_d}), 32'd0);
    check("rst_busy", 32'(clr_busy), 32'd0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    rst_n = 1'b1;
    step();

    // Single write then read on r0
    access(0, 1'b1, 8'h10, 9'h1A5, lat);
    check("t1_wr_gnt_lat", 32'(lat), 32'd1);
    step();
    access(0, 1'b0, 8'h10, 9'h000, lat);
    check("t1_rd_gnt_lat", 32'(lat), 32'd1);
    check("t1_rvalid_early", 32'(r0_rvalid), 32'd0);
    step();
    check("t1_rvalid_lat", 32'(r0_rvalid), 32'd1);
    check("t1_rdata", 32'(r0_rdata), 32'h1A5);
    step();
    check("t1_rvalid_pulse", 32'(r0_rvalid), 32'd0);
    check("t1_rdata_hold", 32'(r0_rdata), 32'h1A5);

    // Fairness with both requesters held high
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'h01; r0_wdata = 9'h0A1;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'h02; r1_wdata = 9'h0B2;
    ref_mem[1] = 9'h0A1;
    ref_mem[2] = 9'h0B2;
    ngr = 0; werun = 0; cyc = 0;
    while (ngr < 6 && cyc < 20) begin
      step();
      cyc++;
      check("t2_both_gnt", 32'(r0_gnt & r1_gnt), 32'd0);
      if (r0_gnt || r1_gnt) begin
        check("t2_order", 32'(r1_gnt), 32'(ngr % 2));
        ngr++;
      end
      if (mem_we) werun++;
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    check("t2_grants", 32'(ngr), 32'd6);
    check("t2_we_cycles", 32'(werun), 32'd6);
    check("t2_span", 32'(cyc), 32'd6);
    step();
    check("t2_we_stop", 32'(mem_we), 32'd0);

    // Fill three addresses then clear the whole memory
    access(0, 1'b1, 8'h00, 9'h155, lat);
    access(1, 1'b1, 8'h7F, 9'h155, lat);
    access(0, 1'b1, 8'hFF, 9'h155, lat);
    step();
    busy_len = 0;
    clr_start = 1'b1;
    wipe(0, DEPTH-1);
    step();
    clr_start = 1'b0;
    check("t3_busy_start", 32'(clr_busy), 32'd1);
    n = 0;
    while (clr_busy && n < 400) begin step(); n++; end
    check("t3_addr_wrap", 32'(mem_a), 32'd0);
    check("t3_we_after", 32'(mem_we), 32'd0);
    step();
    check("t3_busy_len", 32'(busy_len), 32'd256);
    check("t3_sweep_err", 32'(sweep_err), 32'd0);
    access(0, 1'b0, 8'h00, 9'h000, lat);
    access(1, 1'b0, 8'h7F, 9'h000, lat);
    access(0, 1'b0, 8'hFF, 9'h000, lat);
    repeat (3) step();

    // Clear together with an r1 request, plus a redundant clr_start mid-sweep
    busy_len = 0;
    wipe(0, DEPTH-1);
    clr_start = 1'b1;
    fork
      access(1, 1'b1, 8'h33, 9'h0AA, la);
      begin
        step();
        clr_start = 1'b0;
        repeat (100) step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
      end
    join
    check("t4_r1_gnt_lat", 32'(la), 32'd258);
    check("t4_busy_len", 32'(busy_len), 32'd256);
    check("t4_sweep_err", 32'(sweep_err), 32'd0);
    step();
    access(0, 1'b0, 8'h33, 9'h000, lat);
    access(1, 1'b0, 8'h7F, 9'h000, lat);
    repeat (3) step();

    // Reset in the middle of a sweep
    access(0, 1'b1, 8'h20, 9'h0F0, lat);
    access(1, 1'b1, 8'h40, 9'h111, lat);
    access(0, 1'b1, 8'h80, 9'h122, lat);
    access(1, 1'b1, 8'hFF, 9'h133, lat);
    access(0, 1'b0, 8'h40, 9'h000, lat);
    repeat (3) step();
    check("t5_pre_rdata", 32'(r0_rdata), 32'h111);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    n = 0;
    while (!(clr_busy && mem_a == 8'h40) && n < 400) begin step(); n++; end
    check("t5_reached_40", 32'(mem_a), 32'h40);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(clr_busy), 32'd0);
    check("t5_mem", 32'({mem_we, mem_a, mem_d}), 32'd0);
    check("t5_gnt", 32'({r0_gnt, r1_gnt}), 32'd0);
    check("t5_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
    check("t5_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
    check("t5_state", 32'(dut.state), 32'(ST_IDLE));
    wipe(0, 8'h3F);
    step();
    step();
    rst_n = 1'b1;
    step();
    access(0, 1'b0, 8'h20, 9'h000, lat);
    access(1, 1'b0, 8'h3F, 9'h000, lat);
    access(0, 1'b0, 8'h40, 9'h000, lat);
    access(1, 1'b0, 8'h80, 9'h000, lat);
    access(0, 1'b0, 8'hFF, 9'h000, lat);
    repeat (3) step();

    // r1 write immediately followed by r0 read of the same word
    fork
      access(1, 1'b1, 8'h55, 9'h0C3, la);
      begin
        step();
        access(0, 1'b0, 8'h55, 9'h000, lb);
      end
    join
    check("t6_r1_lat", 32'(la), 32'd1);
    check("t6_r0_lat", 32'(lb), 32'd1);
    repeat (3) step();
    check("t6_rdata", 32'(r0_rdata), 32'h0C3);

    check("drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
